// File: rtl/xorn.sv
// Generic N-input XOR reduction; purely combinational.
module xorn #(
  parameter int N = 2
) (
  input  logic [N-1:0] in,
  output logic         out
);

  assign out = ^in;

endmodule

// File: rtl/serial_parity_rx.sv
// Bit-serial frame receiver: N data bits LSB first, then one parity bit.
// Strobes the assembled word and a parity-error flag the cycle after the parity bit.
module serial_parity_rx #(
  parameter int N   = 8,
  parameter int ODD = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_bit,
  input  logic         in_valid,
  output logic [N-1:0] out_data,
  output logic         out_err,
  output logic         out_valid,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  shift;
  logic [CW-1:0] cnt;
  logic          p;

  // The parity bit is still on in_bit when it is folded in with the data.
  xorn #(.N(N + 1)) u_xorn (
    .in  ({in_bit, shift}),
    .out (p)
  );

  assign busy = (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift     <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clr) begin
        shift <= '0;
        cnt   <= '0;
      end else if (in_valid) begin
        if (cnt == CW'(N)) begin
          out_data  <= shift;
          out_err   <= p ^ 1'(ODD);
          out_valid <= 1'b1;
          cnt       <= '0;
        end else begin
          shift <= {in_bit, shift[N-1:1]};
          cnt   <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
